// File: rtl/acc_input_cond.sv
// Key/switch input conditioner: synchronizes SW and KEY_n, debounces the key and emits one
// acc_strobe per qualified press with the operand latched. Optional hold-to-repeat: ACC_AUTO_REPEAT_EN.
module acc_input_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [8:0] SW,
  input  logic       KEY_n,
  output logic [7:0] operand,
  output logic       op_sel,
  output logic       acc_strobe,
  output logic       key_held
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("acc_input_cond: DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      key_sync_reg;
  logic [8:0]      sw_sync1_reg, sw_sync2_reg;
  logic [7:0]      operand_reg;
  logic            op_sel_reg;
  logic            strobe_reg;
  logic            load;
  logic            load_any;
  logic            key_s;

  assign key_s = key_sync_reg[1];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!key_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          load       = 1'b1;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (key_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A single low sample means the key is still down: back to HELD without a strobe.
        if (!key_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef ACC_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_reg, rep_next;
  logic          rep_fire;

  // Counts only while HELD with the key still down; any other state clears it.
  always_comb begin
    rep_next = '0;
    rep_fire = 1'b0;
    if (state_reg == HELD && !key_s) begin
      if (rep_reg == REP_LAST) begin
        rep_fire = 1'b1;
      end else if (rep_reg != '1) begin
        rep_next = rep_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rep_reg <= '0;
    end else begin
      rep_reg <= rep_next;
    end
  end

  assign load_any = load | rep_fire;
`else
  assign load_any = load;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      key_sync_reg <= 2'b11;
      sw_sync1_reg <= '0;
      sw_sync2_reg <= '0;
      operand_reg  <= 8'h00;
      op_sel_reg   <= 1'b0;
      strobe_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      key_sync_reg <= {key_sync_reg[0], KEY_n};
      sw_sync1_reg <= SW;
      sw_sync2_reg <= sw_sync1_reg;
      strobe_reg   <= load_any;
      if (load_any) begin
        operand_reg <= sw_sync2_reg[7:0];
        op_sel_reg  <= sw_sync2_reg[8];
      end
    end
  end

  assign operand    = operand_reg;
  assign op_sel     = op_sel_reg;
  assign acc_strobe = strobe_reg;
  assign key_held   = (state_reg == HELD) || (state_reg == RELEASE_WAIT);

endmodule

// File: tb/tb_acc_input_cond.sv
// Bench for acc_input_cond (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8): vector table, hand-written
// reset/repeat sequences and a randomized run against a run-length reference model.
module tb_acc_input_cond;

  localparam int D = 4;
  localparam int R = 8;
`ifdef ACC_AUTO_REPEAT_EN
  localparam bit AUTO_REP = 1'b1;
`else
  localparam bit AUTO_REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] sw;
  logic       key_n;
  logic [7:0] operand;
  logic       op_sel;
  logic       acc_strobe;
  logic       key_held;

  int checks = 0;
  int errors = 0;

  acc_input_cond #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .CLOCK_50(clk), .reset(rst), .SW(sw), .KEY_n(key_n),
    .operand(operand), .op_sel(op_sel), .acc_strobe(acc_strobe), .key_held(key_held)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       key;
    logic [8:0] sw;
    logic       st;
    logic       held;
    logic [7:0] op;
    logic       sel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic k, input logic [8:0] s, input logic st,
                     input logic h, input logic [7:0] op, input logic sel, input int n);
    vec_t v;
    v.rst = r; v.key = k; v.sw = s; v.st = st; v.held = h; v.op = op; v.sel = sel;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cyc(input logic r, input logic k, input logic [8:0] s);
    rst = r; key_n = k; sw = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic st, input logic h,
                            input logic [7:0] op, input logic sel);
    check({tag, ".strobe"}, 32'(acc_strobe), 32'(st));
    check({tag, ".held"}, 32'(key_held), 32'(h));
    check({tag, ".operand"}, 32'(operand), 32'(op));
    check({tag, ".op_sel"}, 32'(op_sel), 32'(sel));
  endtask

  // Reference model: qualification after D+1 consecutive low synchronized samples,
  // release after D+1 consecutive high ones; optional repeat every R further low samples.
  logic       m_k1, m_k2;
  logic [8:0] m_s1, m_s2;
  logic       m_pressed, m_st, m_sel;
  logic [7:0] m_op;
  int         m_low, m_high, m_rep;

  task automatic model_step(input logic r, input logic k, input logic [8:0] s);
    logic smp;
    if (r) begin
      m_k1 = 1'b1; m_k2 = 1'b1; m_s1 = '0; m_s2 = '0;
      m_pressed = 1'b0; m_st = 1'b0; m_op = 8'h00; m_sel = 1'b0;
      m_low = 0; m_high = 0; m_rep = -1;
      return;
    end
    smp = m_k2;
    m_st = 1'b0;
    if (smp) begin m_high++; m_low = 0; end
    else begin m_low++; m_high = 0; end
    if (!m_pressed) begin
      if (m_low >= D + 1) begin
        m_pressed = 1'b1; m_st = 1'b1; m_op = m_s2[7:0]; m_sel = m_s2[8]; m_rep = 0;
      end
    end else if (m_high >= D + 1) begin
      m_pressed = 1'b0;
    end else if (AUTO_REP) begin
      if (smp) m_rep = -1;
      else if (m_rep < 0) m_rep = 0;
      else begin
        m_rep++;
        if (m_rep == R) begin
          m_st = 1'b1; m_op = m_s2[7:0]; m_sel = m_s2[8]; m_rep = 0;
        end
      end
    end
    m_k2 = m_k1; m_k1 = k;
    m_s2 = m_s1; m_s1 = s;
  endtask

  initial begin
    bit found;
    int run_left;
    logic k;
    logic [8:0] s;
    logic r;

    rst = 1'b1; key_n = 1'b1; sw = '0;
    @(negedge clk);

    // Reset, idle, clean press held 20 cycles, SW change, bouncy release, then a glitchy press.
    add(1, 1, 9'h000, 0, 0, 8'h00, 0, 3);
    add(0, 1, 9'h000, 0, 0, 8'h00, 0, 10);
    add(0, 0, 9'h1A5, 0, 0, 8'h00, 0, 6);
    add(0, 0, 9'h1A5, 1, 1, 8'hA5, 1, 1);
    add(0, 0, 9'h1A5, 0, 1, 8'hA5, 1, 7);
    add(0, 0, 9'h1A5, AUTO_REP, 1, 8'hA5, 1, 1);
    add(0, 0, 9'h033, 0, 1, 8'hA5, 1, 5);
    add(0, 1, 9'h033, 0, 1, 8'hA5, 1, 1);
    add(0, 0, 9'h033, 0, 1, 8'hA5, 1, 1);
    add(0, 1, 9'h033, 0, 1, 8'hA5, 1, 1);
    add(0, 0, 9'h033, 0, 1, 8'hA5, 1, 1);
    add(0, 1, 9'h033, 0, 1, 8'hA5, 1, 6);
    add(0, 1, 9'h033, 0, 0, 8'hA5, 1, 3);
    add(0, 0, 9'h0FF, 0, 0, 8'hA5, 1, 2);
    add(0, 1, 9'h0FF, 0, 0, 8'hA5, 1, 1);
    add(0, 0, 9'h0FF, 0, 0, 8'hA5, 1, 2);
    add(0, 1, 9'h0FF, 0, 0, 8'hA5, 1, 8);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].key, tbl[i].sw);
      check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].held, tbl[i].op, tbl[i].sel);
    end

    // Reset pulse in the middle of a press: a full fresh debounce is needed afterwards.
    for (int i = 0; i < 4; i++) cyc(0, 0, 9'h15A);
    cyc(1, 0, 9'h15A);
    check_outs("midreset", 0, 0, 8'h00, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 9'h15A);
      check($sformatf("postreset%0d.strobe", i), 32'(acc_strobe), 32'(i == 7));
      if (i == 7) check_outs("postreset.qual", 1, 1, 8'h5A, 1);
    end
    for (int i = 0; i < 10; i++) cyc(0, 1, 9'h15A);
    check("postreset.release", 32'(key_held), 32'(0));

    // Hold-to-repeat: strobes every R cycles only when the feature is built in.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 0, 9'h001);
      found = acc_strobe;
    end
    check("repeat.qualified", 32'(found), 32'(1));
    check("repeat.operand", 32'(operand), 32'h01);
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 0, 9'h001);
      check($sformatf("repeat+%0d.strobe", i), 32'(acc_strobe), 32'(AUTO_REP && (i % R == 0)));
    end
    for (int i = 0; i < 10; i++) cyc(0, 1, 9'h001);
    check("repeat.release", 32'(key_held), 32'(0));

    // Randomized run against the model, starting from a reset it sees too.
    model_step(1, 1, '0);
    cyc(1, 1, '0);
    check_outs("rnd.reset", m_st, m_pressed, m_op, m_sel);
    k = 1'b1; s = '0; run_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (run_left == 0) begin
        k = ~k;
        run_left = $urandom_range(1, 8);
      end
      run_left--;
      if ($urandom_range(0, 3) == 0) s = 9'($urandom);
      r = ($urandom_range(0, 249) == 0);
      model_step(r, k, s);
      cyc(r, k, s);
      check_outs($sformatf("rnd%0d", n), m_st, m_pressed, m_op, m_sel);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
